if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register, the next-PC selection and the IF/ID pipeline register.
- Inputs:
  - the 3-bit branch_jump code resolved in ID;
  - the flush bit that the flusher derives from that same code;
  - stall from the hazard unit.
- Outputs: the instruction-memory address and the registered IF/ID payload to the decode stage.

---
 rtl/if_stage_pkg.sv | 20 ++
 rtl/if_stage_if_id_reg.sv | 46 ++++
 rtl/if_stage.sv | 93 +++++++++
 tb/tb_if_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants for the fetch path: branch/jump control codes, reset PC and
// the NOP word. The flusher and control decoder use the same constants.
package if_stage_pkg;

    typedef enum logic [2:0] {
        BJ_NONE   = 3'd0,
        BJ_BRANCH = 3'd1,
        BJ_JUMP   = 3'd2,
        BJ_JR     = 3'd3
    } bj_e;

    localparam logic [31:0] RESET_PC_C  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_C = 32'h0000_0000;

    // Codes 4-7 are reserved and never redirect.
    function automatic logic is_redirect(input logic [2:0] bj);
        return (bj == BJ_BRANCH) || (bj == BJ_JUMP) || (bj == BJ_JR);
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall holds, otherwise load.
// o_load flags the edges that capture a real instruction.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic        i_stall,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc4,
    output logic        o_valid,
    output logic        o_load
);

    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    assign o_load  = !i_flush && !i_stall;
    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            // The squashed slot still carries its PC+4 so ID sees a coherent bubble.
            r_instr <= NOP_INSTR;
            r_pc4   <= i_pc4;
            r_valid <= 1'b0;
        end else if (!i_stall) begin
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
            r_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register and
// saturating fetch/flush performance counters.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_C,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic [2:0]       branch_jump,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      jump_target,
    input  logic [31:0]      jr_target,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      imem_addr,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_fetch_count;
    logic [CNT_W-1:0] r_flush_count;
    logic [31:0]      w_pc4;
    logic [31:0]      w_next_pc;
    logic             w_load;

    assign w_pc4     = r_pc + 32'd4;
    assign imem_addr = r_pc;

    // A resolved redirect must win over stall, or the target would be lost.
    always_comb begin
        w_next_pc = w_pc4;
        if (is_redirect(branch_jump)) begin
            case (branch_jump)
                BJ_BRANCH: w_next_pc = branch_target;
                BJ_JUMP:   w_next_pc = jump_target;
                default:   w_next_pc = jr_target;
            endcase
        end else if (stall) begin
            w_next_pc = r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (flush),
        .i_stall (stall),
        .i_instr (imem_rdata),
        .i_pc4   (w_pc4),
        .o_instr (if_id_instr),
        .o_pc4   (if_id_pc4),
        .o_valid (if_id_valid),
        .o_load  (w_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_load && (r_fetch_count != CNT_MAX)) begin
                r_fetch_count <= r_fetch_count + CNT_W'(1);
            end
            if (flush && (r_flush_count != CNT_MAX)) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign flush_count = r_flush_count;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run
// against a cycle-level reference model of the fetch rules.
module tb_if_stage;

  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic [2:0]    branch_jump = 3'd0;
  logic [31:0]   branch_target = 32'd0;
  logic [31:0]   jump_target = 32'd0;
  logic [31:0]   jr_target = 32'd0;
  logic [31:0]   imem_rdata;
  logic [31:0]   imem_addr;
  logic [31:0]   if_id_instr;
  logic [31:0]   if_id_pc4;
  logic          if_id_valid;
  logic [CW-1:0] fetch_count;
  logic [CW-1:0] flush_count;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [31:0]   m_pc, m_instr, m_pc4;
  logic          m_valid;
  logic [CW-1:0] m_fc, m_flc;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP),
    .CNT_W    (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .branch_jump  (branch_jump),
    .branch_target(branch_target),
    .jump_target  (jump_target),
    .jr_target    (jr_target),
    .imem_rdata   (imem_rdata),
    .imem_addr    (imem_addr),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .fetch_count  (fetch_count),
    .flush_count  (flush_count)
  );

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input logic r, input logic s, input logic f, input logic [2:0] bj,
                       input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] jrt);
    logic [31:0]   n_pc, n_instr, n_pc4, seq;
    logic          n_valid;
    logic [CW-1:0] n_fc, n_flc;
    rst = r; stall = s; flush = f; branch_jump = bj;
    branch_target = bt; jump_target = jt; jr_target = jrt;
    seq = m_pc + 32'd4;
    n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid; n_fc = m_fc; n_flc = m_flc;
    if (r) begin
      n_pc = 32'd0; n_instr = NOP; n_pc4 = 32'd0; n_valid = 1'b0; n_fc = '0; n_flc = '0;
    end else begin
      if (bj == 3'd1)      n_pc = bt;
      else if (bj == 3'd2) n_pc = jt;
      else if (bj == 3'd3) n_pc = jrt;
      else if (s)          n_pc = m_pc;
      else                 n_pc = seq;
      if (f) begin
        n_instr = NOP; n_pc4 = seq; n_valid = 1'b0;
      end else if (!s) begin
        n_instr = mem_word(m_pc); n_pc4 = seq; n_valid = 1'b1;
        if (m_fc != CMAX) n_fc = m_fc + 1'b1;
      end
      if (f && m_flc != CMAX) n_flc = m_flc + 1'b1;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid; m_fc = n_fc; m_flc = n_flc;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
    vectors++;
    if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid, fetch_count, flush_count} !==
        {32'd0, NOP, 32'd0, 1'b0, {CW{1'b0}}, {CW{1'b0}}}) begin
      miscompares++;
      $display("FAIL reset act=%h/%h/%h/%b/%h/%h exp=0/NOP/0/0/0/0", imem_addr, if_id_instr,
               if_id_pc4, if_id_valid, fetch_count, flush_count);
    end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
      vectors++;
      if (imem_addr !== 32'(4 * i) || if_id_valid !== 1'b1 ||
          if_id_instr !== mem_word(32'(4 * (i - 1))) || if_id_pc4 !== 32'(4 * i)) begin
        miscompares++;
        $display("FAIL seq_%0d act pc=%h instr=%h pc4=%h v=%b", i, imem_addr, if_id_instr,
                 if_id_pc4, if_id_valid);
      end
    end
    vectors++;
    if (fetch_count !== 4'd3) begin
      miscompares++;
      $display("FAIL seq_fetch_count act=%0d exp=3", fetch_count);
    end
  endtask

  task automatic test_branch_flush();
    cycle(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
    vectors++;
    if (imem_addr !== 32'h10) begin
      miscompares++;
      $display("FAIL br_setup act=%h exp=00000010", imem_addr);
    end
    cycle(1'b0, 1'b0, 1'b1, 3'd1, 32'h40, 32'h0, 32'h0);
    vectors++;
    if (imem_addr !== 32'h40 || if_id_instr !== NOP || if_id_valid !== 1'b0 ||
        flush_count !== 4'd1) begin
      miscompares++;
      $display("FAIL br_redirect act pc=%h instr=%h v=%b flc=%0d exp 40/NOP/0/1", imem_addr,
               if_id_instr, if_id_valid, flush_count);
    end
    cycle(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
    vectors++;
    if (if_id_instr !== mem_word(32'h40) || if_id_pc4 !== 32'h44 || if_id_valid !== 1'b1 ||
        imem_addr !== 32'h44) begin
      miscompares++;
      $display("FAIL br_target act instr=%h pc4=%h v=%b pc=%h exp %h/44/1/44", if_id_instr,
               if_id_pc4, if_id_valid, imem_addr, mem_word(32'h40));
    end
  endtask

  task automatic test_stall();
    logic [31:0]   h_instr, h_pc4;
    logic [CW-1:0] h_fc;
    cycle(1'b0, 1'b0, 1'b1, 3'd2, 32'h0, 32'h1C, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
    h_instr = if_id_instr; h_pc4 = if_id_pc4; h_fc = fetch_count;
    vectors++;
    if (imem_addr !== 32'h20 || h_instr !== mem_word(32'h1C)) begin
      miscompares++;
      $display("FAIL stall_setup act pc=%h instr=%h exp 20/%h", imem_addr, h_instr,
               mem_word(32'h1C));
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
      vectors++;
      if (imem_addr !== 32'h20 || if_id_instr !== h_instr || if_id_pc4 !== h_pc4 ||
          if_id_valid !== 1'b1 || fetch_count !== h_fc) begin
        miscompares++;
        $display("FAIL stall_hold_%0d act pc=%h instr=%h pc4=%h fc=%0d exp 20/%h/%h/%0d", i,
                 imem_addr, if_id_instr, if_id_pc4, fetch_count, h_instr, h_pc4, h_fc);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
    vectors++;
    if (imem_addr !== 32'h24 || if_id_instr !== mem_word(32'h20) || if_id_pc4 !== 32'h24) begin
      miscompares++;
      $display("FAIL stall_release act pc=%h instr=%h pc4=%h exp 24/%h/24", imem_addr,
               if_id_instr, if_id_pc4, mem_word(32'h20));
    end
  endtask

  task automatic test_stall_redirect();
    cycle(1'b0, 1'b1, 1'b1, 3'd3, 32'h0, 32'h0, 32'h100);
    vectors++;
    if (imem_addr !== 32'h100 || if_id_instr !== NOP || if_id_valid !== 1'b0 ||
        if_id_pc4 !== m_pc4 || flush_count !== m_flc) begin
      miscompares++;
      $display("FAIL stall_jr act pc=%h instr=%h v=%b pc4=%h flc=%0d exp 100/NOP/0/%h/%0d",
               imem_addr, if_id_instr, if_id_valid, if_id_pc4, flush_count, m_pc4, m_flc);
    end
  endtask

  task automatic test_wrap();
    cycle(1'b0, 1'b0, 1'b1, 3'd3, 32'h0, 32'h0, 32'hFFFF_FFFC);
    vectors++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_setup act=%h exp=fffffffc", imem_addr);
    end
    cycle(1'b0, 1'b0, 1'b0, 3'd5, 32'h0, 32'h0, 32'h0);
    vectors++;
    if (imem_addr !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b1 ||
        if_id_instr !== mem_word(32'hFFFF_FFFC)) begin
      miscompares++;
      $display("FAIL wrap act pc=%h pc4=%h v=%b exp 0/0/1", imem_addr, if_id_pc4, if_id_valid);
    end
  endtask

  task automatic test_reset_saturation();
    cycle(1'b1, 1'b1, 1'b0, 3'd2, 32'h0, 32'h300, 32'h0);
    vectors++;
    if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid, fetch_count, flush_count} !==
        {32'd0, NOP, 32'd0, 1'b0, {CW{1'b0}}, {CW{1'b0}}}) begin
      miscompares++;
      $display("FAIL reset_mid_stall act=%h/%h/%h/%b/%h/%h exp=0/NOP/0/0/0/0", imem_addr,
               if_id_instr, if_id_pc4, if_id_valid, fetch_count, flush_count);
    end
    for (int i = 0; i < 18; i++) cycle(1'b0, 1'b0, 1'b1, 3'd1, 32'h200, 32'h0, 32'h0);
    vectors++;
    if (flush_count !== CMAX || fetch_count !== 4'd0) begin
      miscompares++;
      $display("FAIL flush_sat act flc=%0d fc=%0d exp 15/0", flush_count, fetch_count);
    end
    for (int i = 0; i < 18; i++) cycle(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0);
    vectors++;
    if (fetch_count !== CMAX || flush_count !== CMAX) begin
      miscompares++;
      $display("FAIL fetch_sat act fc=%0d flc=%0d exp 15/15", fetch_count, flush_count);
    end
  endtask

  task automatic test_random();
    logic [2:0] bj;
    logic       s, f, r;
    cycle(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 400; i++) begin
      bj = 3'($urandom_range(0, 7));
      f  = (bj >= 3'd1 && bj <= 3'd3);
      s  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 99) == 0);
      cycle(r, s, f, bj, {$urandom(), 2'b00} >> 2 << 2, {$urandom()} & 32'hFFFF_FFFC,
            {$urandom()} & 32'hFFFF_FFFC);
      vectors++;
      if ({imem_addr, if_id_instr, if_id_pc4, if_id_valid, fetch_count, flush_count} !==
          {m_pc, m_instr, m_pc4, m_valid, m_fc, m_flc}) begin
        miscompares++;
        $display("FAIL rand_%0d act=%h/%h/%h/%b/%h/%h exp=%h/%h/%h/%b/%h/%h", i, imem_addr,
                 if_id_instr, if_id_pc4, if_id_valid, fetch_count, flush_count, m_pc, m_instr,
                 m_pc4, m_valid, m_fc, m_flc);
      end
    end
  endtask

  initial begin
    m_pc = 32'd0; m_instr = NOP; m_pc4 = 32'd0; m_valid = 1'b0; m_fc = '0; m_flc = '0;
    test_reset();
    test_sequential();
    test_branch_flush();
    test_stall();
    test_stall_redirect();
    test_wrap();
    test_reset_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
